// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
// Contents:
//   DATA_WIDTH, INSTRUCTION_WIDTH, ZERO_DATA - datapath widths and zero constant
//   IQ_DEPTH_DEFAULT, IQ_WIDTH               - default queue depth and its index range
//   fetch_state_e                            - fetch FSM encodings (2-bit)
//   iq_entry_t                               - one queued {inst, pc} record
//   next_pc()                                - sequential (not-taken) successor PC
package fetch_unit_pkg;

    localparam int unsigned DATA_WIDTH        = 32;
    localparam int unsigned INSTRUCTION_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

    localparam int unsigned IQ_DEPTH_DEFAULT = 8;
    localparam int unsigned IQ_WIDTH         = $clog2(IQ_DEPTH_DEFAULT);

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] inst;
        logic [DATA_WIDTH-1:0]        pc;
    } iq_entry_t;

    // Static not-taken prediction; wraps modulo 2^32.
    function automatic logic [DATA_WIDTH-1:0] next_pc(input logic [DATA_WIDTH-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_inst_queue.sv
// Synchronous FIFO of {inst, pc} records between fetch and decode.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - synchronous flush, overrides push and pop on the same edge
//   push       - write push_entry at the tail (ignored when full)
//   pop        - drop the head entry (ignored when empty)
//   count      - number of valid entries (0..DEPTH)
//   full/empty - occupancy flags
//   head       - head entry, all-zero when empty
module fetch_unit_inst_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  iq_entry_t   push_entry,
    input  logic        pop,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty,
    output iq_entry_t   head
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    iq_entry_t   mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0] head_ptr;
    logic [AW:0] tail_ptr;
    logic        push_en;
    logic        pop_en;

    assign count   = tail_ptr - head_ptr;
    assign full    = (count == FULL_COUNT);
    assign empty   = (head_ptr == tail_ptr);
    assign push_en = push && !full && !clear;
    assign pop_en  = pop && !empty && !clear;
    assign head    = empty ? '0 : mem[head_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (push_en) tail_ptr <= tail_ptr + 1'b1;
            if (pop_en)  head_ptr <= head_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[tail_ptr[AW-1:0]] <= push_entry;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, one outstanding
// memory request at a time, instruction queue towards decode, ROB redirect.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   flush_ena, flush_pc          - ROB redirect request and target
//   mem_req_ena, mem_req_addr    - registered one-cycle fetch request
//   mem_resp_valid, mem_resp_inst- returned instruction word
//   decode_ready                 - decode can accept the queue head
//   out_valid, out_inst, out_pc  - queue head presented to decode
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned           IQ_DEPTH = IQ_DEPTH_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_ena,
    input  logic [DATA_WIDTH-1:0]        flush_pc,
    output logic                         mem_req_ena,
    output logic [DATA_WIDTH-1:0]        mem_req_addr,
    input  logic                         mem_resp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_resp_inst,
    input  logic                         decode_ready,
    output logic                         out_valid,
    output logic [INSTRUCTION_WIDTH-1:0] out_inst,
    output logic [DATA_WIDTH-1:0]        out_pc
);

    localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

    fetch_state_e          state;
    logic [DATA_WIDTH-1:0] pc;

    logic          iq_push;
    logic          iq_pop;
    iq_entry_t     iq_in;
    iq_entry_t     iq_head;
    logic [CW-1:0] iq_count;
    logic          iq_full;
    logic          iq_empty;
    logic          unused_count;

    // Flush wins over any same-edge push or pop.
    assign iq_push      = (state == FETCH_WAIT) && mem_resp_valid && !flush_ena;
    assign iq_pop       = !iq_empty && decode_ready && !flush_ena;
    assign iq_in        = '{inst: mem_resp_inst, pc: pc};
    assign unused_count = ^iq_count;

    assign out_valid = !iq_empty;
    assign out_inst  = iq_head.inst;
    assign out_pc    = iq_head.pc;

    fetch_unit_inst_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_inst_queue (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush_ena),
        .push       (iq_push),
        .push_entry (iq_in),
        .pop        (iq_pop),
        .count      (iq_count),
        .full       (iq_full),
        .empty      (iq_empty),
        .head       (iq_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH_IDLE;
            pc           <= RESET_PC;
            mem_req_ena  <= 1'b0;
            mem_req_addr <= ZERO_DATA;
        end else begin
            mem_req_ena <= 1'b0;
            case (state)
                FETCH_IDLE: begin
                    if (flush_ena) begin
                        pc <= flush_pc;
                    end else if (!iq_full) begin
                        // Issuing only below full guarantees room for the response.
                        state        <= FETCH_WAIT;
                        mem_req_ena  <= 1'b1;
                        mem_req_addr <= pc;
                    end
                end
                FETCH_WAIT: begin
                    if (flush_ena) begin
                        pc    <= flush_pc;
                        state <= mem_resp_valid ? FETCH_IDLE : FETCH_DISCARD;
                    end else if (mem_resp_valid) begin
                        pc    <= next_pc(pc);
                        state <= FETCH_IDLE;
                    end
                end
                FETCH_DISCARD: begin
                    // Waiting out the stale response of a flushed request.
                    if (flush_ena)      pc    <= flush_pc;
                    if (mem_resp_valid) state <= FETCH_IDLE;
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] IXOR = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_ena = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        mem_req_ena;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_inst = 32'h0;
    logic        decode_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Memory model: response sampled mem_lat edges after the request edge.
    int          mem_lat   = 1;
    int          pend      = 0;
    logic [31:0] mem_addr  = 32'h0;
    bit          inst_mode = 1'b0;

    fetch_unit #(
        .IQ_DEPTH (8),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_ena      (flush_ena),
        .flush_pc       (flush_pc),
        .mem_req_ena    (mem_req_ena),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_inst  (mem_resp_inst),
        .decode_ready   (decode_ready),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_req_ena) begin
            pend     = mem_lat;
            mem_addr = mem_req_addr;
        end else if (pend > 0) begin
            pend = pend - 1;
        end
        mem_resp_valid = (pend == 1);
        mem_resp_inst  = (pend == 1) ? (inst_mode ? (mem_addr ^ IXOR) : 32'h13) : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ena"},  {31'b0, mem_req_ena}, 32'h0);
        chk({tag, "_req_addr"}, mem_req_addr, 32'h0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
        chk({tag, "_out_inst"}, out_inst, 32'h0);
        chk({tag, "_out_pc"},   out_pc, 32'h0);
    endtask

    // Ends at a negedge with rst just released; long enough for stale responses to expire.
    task automatic do_reset();
        rst          = 1'b1;
        flush_ena    = 1'b0;
        decode_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ready;
        logic        req_ena;
        logic        chk_addr;
        logic [31:0] req_addr;
        logic        ov;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vt [7];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          n;
        int          pops;
        bit          found;
        bit          got;
        bit          resumed;
        logic [31:0] exp_req [2];

        // 1-cycle memory, decode always ready: one request every 2 cycles.
        vt[0] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h13};
        vt[3] = '{1'b1, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
        vt[4] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 32'h13};
        vt[5] = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
        vt[6] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 32'h13};

        repeat (2) @(negedge clk);
        inst_mode = 1'b0;
        mem_lat   = 1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            decode_ready = vt[i].ready;
            chk("t1_req_ena", {31'b0, mem_req_ena}, {31'b0, vt[i].req_ena});
            if (vt[i].chk_addr) chk("t1_req_addr", mem_req_addr, vt[i].req_addr);
            chk("t1_out_valid", {31'b0, out_valid}, {31'b0, vt[i].ov});
            chk("t1_out_pc", out_pc, vt[i].pc);
            chk("t1_out_inst", out_inst, vt[i].inst);
            @(negedge clk);
        end

        // Decode stalled: exactly 8 requests fill the queue, then drain in order.
        inst_mode = 1'b1;
        do_reset();
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (mem_req_ena) begin
                chk("t2_fill_addr", mem_req_addr, 32'(n * 4));
                n++;
            end
            @(negedge clk);
        end
        chk("t2_req_count", 32'(n), 32'd8);
        chk("t2_head_valid", {31'b0, out_valid}, 32'h1);
        chk("t2_head_pc", out_pc, 32'h0);
        decode_ready = 1'b1;
        pops    = 0;
        resumed = 1'b0;
        for (int c = 0; c < 40 && (pops < 8 || !resumed); c++) begin
            if (out_valid && pops < 8) begin
                chk("t2_drain_pc", out_pc, 32'(pops * 4));
                chk("t2_drain_inst", out_inst, 32'(pops * 4) ^ IXOR);
                pops++;
            end
            if (mem_req_ena && !resumed) begin
                chk("t2_resume_addr", mem_req_addr, 32'h20);
                resumed = 1'b1;
            end
            @(negedge clk);
        end
        chk("t2_drained", 32'(pops), 32'd8);
        chk("t2_resumed", {31'b0, resumed}, 32'h1);

        // 3-cycle memory, flush while the request to 0x8 is in flight.
        mem_lat = 3;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mem_req_ena && mem_req_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t3_req8_seen", {31'b0, found}, 32'h1);
        @(negedge clk);
        flush_ena = 1'b1;
        flush_pc  = 32'h100;
        @(negedge clk);
        flush_ena = 1'b0;
        chk("t3_cleared_valid", {31'b0, out_valid}, 32'h0);
        chk("t3_cleared_pc", out_pc, 32'h0);
        decode_ready = 1'b1;
        found = 1'b0;
        got   = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (mem_req_ena && !found) begin
                chk("t3_redirect_addr", mem_req_addr, 32'h100);
                found = 1'b1;
            end
            if (out_valid) begin
                chk("t3_first_pc", out_pc, 32'h100);
                chk("t3_first_inst", out_inst, 32'h100 ^ IXOR);
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t3_got_output", {31'b0, got}, 32'h1);

        // Flush coincides with a response and a pop, queue holding 4 entries.
        mem_lat = 1;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mem_req_ena && mem_req_addr == 32'h10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t4_req10_seen", {31'b0, found}, 32'h1);
        chk("t4_head_before", out_pc, 32'h0);
        flush_ena    = 1'b1;
        flush_pc     = 32'h200;
        decode_ready = 1'b1;
        @(negedge clk);
        flush_ena    = 1'b0;
        decode_ready = 1'b0;
        chk("t4_valid_after_flush", {31'b0, out_valid}, 32'h0);
        exp_req[0] = 32'h200;
        exp_req[1] = 32'h204;
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 30 && (n < 2 || !got); c++) begin
            if (mem_req_ena && n < 2) begin
                chk("t4_req_addr", mem_req_addr, exp_req[n]);
                n++;
            end
            if (out_valid && !got) begin
                chk("t4_first_pc", out_pc, 32'h200);
                got = 1'b1;
            end
            @(negedge clk);
        end
        chk("t4_req_count", 32'(n), 32'd2);
        chk("t4_got_output", {31'b0, got}, 32'h1);

        // PC wraps from 0xFFFFFFFC to 0.
        do_reset();
        decode_ready = 1'b1;
        flush_ena    = 1'b1;
        flush_pc     = 32'hFFFF_FFFC;
        @(negedge clk);
        flush_ena = 1'b0;
        chk("t5_no_req_on_flush", {31'b0, mem_req_ena}, 32'h0);
        exp_req[0] = 32'hFFFF_FFFC;
        exp_req[1] = 32'h0;
        n    = 0;
        pops = 0;
        for (int c = 0; c < 30 && (n < 2 || pops < 2); c++) begin
            if (mem_req_ena && n < 2) begin
                chk("t5_req_addr", mem_req_addr, exp_req[n]);
                n++;
            end
            if (out_valid && pops < 2) begin
                chk("t5_out_pc", out_pc, exp_req[pops]);
                chk("t5_out_inst", out_inst, exp_req[pops] ^ IXOR);
                pops++;
            end
            @(negedge clk);
        end
        chk("t5_req_count", 32'(n), 32'd2);
        chk("t5_pop_count", 32'(pops), 32'd2);

        // Reset mid-WAIT; the stray response after release must be ignored.
        mem_lat = 3;
        do_reset();
        decode_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_req_ena) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_first_req_seen", {31'b0, found}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_outputs("t6_in_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("t6_req_ena", {31'b0, mem_req_ena}, 32'h1);
                chk("t6_req_addr", mem_req_addr, 32'h0);
            end
            chk("t6_out_valid", {31'b0, out_valid}, {31'b0, (k == 4)});
            if (k == 4) begin
                chk("t6_out_pc", out_pc, 32'h0);
                chk("t6_out_inst", out_inst, 32'h0 ^ IXOR);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
